frame_writer: RTL and testbench

Write-side address generator for the 240-column pixel frame buffer. Accepts a raster pixel stream from the camera capture path, optionally decimates it 2:1 and mirrors it horizontally, and issues BRAM write strobes at linear address col + 240*row. It pairs with the display-side read address generator, which uses the same scale/mirror encoding and the same 240-wide, 17-bit address map.

---
 rtl/frame_writer.sv | 157 +++++++++++++++
 tb/tb_frame_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// frame_writer: raster pixel stream to frame-buffer write strobes.
// Optional 2:1 decimation and horizontal mirror, latched per frame.
module frame_writer #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sof_in,
    input  logic              valid_in,
    input  logic              eol_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        scale_in,
    input  logic              mirror_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              we_out,
    output logic              frame_done_out,
    output logic              busy_out
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        WAIT_SOF,
        CAPTURE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                dec_q, dec_d;
    logic                mir_q, mir_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_q, we_d;
    logic                done_q, done_d;

    // Effective per-cycle view: a sof restarts the frame in the same cycle
    logic                active;
    logic                dec;
    logic                mir;
    logic [CNT_W-1:0]    col;
    logic [CNT_W-1:0]    row;
    logic [ADDR_W-1:0]   base;
    logic                keep;
    logic                keep_row;
    logic                last_row;
    logic [CNT_W-1:0]    oc;
    logic [ADDR_W-1:0]   acol;

    // Next-state, counters and write strobe generation
    always_comb begin
        state_d  = state_q;
        dec_d    = dec_q;
        mir_d    = mir_q;
        col_d    = col_q;
        row_d    = row_q;
        base_d   = base_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        active   = (state_q == CAPTURE);
        dec      = dec_q;
        mir      = mir_q;
        col      = col_q;
        row      = row_q;
        base     = base_q;

        if (sof_in) begin
            active  = 1'b1;
            dec     = (scale_in == 2'b01);
            mir     = mirror_in;
            col     = '0;
            row     = '0;
            base    = '0;
            state_d = CAPTURE;
            dec_d   = dec;
            mir_d   = mir;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
        end

        keep_row = !dec || !row[0];
        keep     = keep_row && (!dec || !col[0]);
        oc       = dec ? (col >> 1) : col;
        acol     = mir ? (ADDR_W'(WIDTH - 1) - ADDR_W'(oc))
                       : ADDR_W'(oc);
        last_row = dec ? (row == CNT_W'(2 * HEIGHT - 1))
                       : (row == CNT_W'(HEIGHT - 1));

        if (active) begin
            if (valid_in) begin
                // Saturate so overlong lines can never wrap back in range
                if (col != '1) begin
                    col_d = col + CNT_W'(1);
                end
                if (keep && (oc < CNT_W'(WIDTH))) begin
                    we_d   = 1'b1;
                    addr_d = acol + base;
                    data_d = data_in;
                end
            end
            if (eol_in) begin
                col_d = '0;
                row_d = row + CNT_W'(1);
                if (keep_row) begin
                    base_d = base + ADDR_W'(WIDTH);
                end
                if (last_row) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= WAIT_SOF;
            dec_q   <= 1'b0;
            mir_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            mir_q   <= mir_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    assign addr_out       = addr_q;
    assign data_out       = data_q;
    assign we_out         = we_q;
    assign frame_done_out = done_q;
    assign busy_out       = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: scoreboard bench for frame_writer.
// Expected writes and done pulses are queued with their cycle stamp.
module tb_frame_writer;

    localparam int H = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        sof_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        eol_in = 1'b0;
    logic [15:0] data_in = '0;
    logic [1:0]  scale_in = '0;
    logic        mirror_in = 1'b0;
    logic [16:0] addr_out;
    logic [15:0] data_out;
    logic        we_out;
    logic        frame_done_out;
    logic        busy_out;

    frame_writer #(
        .WIDTH (240),
        .HEIGHT(H),
        .ADDR_W(17),
        .DATA_W(16)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .sof_in        (sof_in),
        .valid_in      (valid_in),
        .eol_in        (eol_in),
        .data_in       (data_in),
        .scale_in      (scale_in),
        .mirror_in     (mirror_in),
        .addr_out      (addr_out),
        .data_out      (data_out),
        .we_out        (we_out),
        .frame_done_out(frame_done_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit is_done;
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   wmap[int];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   wcount = 0;
    int   dcount = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: pop and compare whenever the DUT presents an output
    always @(negedge clk_in) begin
        exp_t e;
        if (we_out) begin
            wcount++;
            wmap[int'(data_out)] = int'(addr_out);
            total++;
            if (q.size() == 0 || q[0].is_done) begin
                $display("FAIL unexpected_write: got addr %0d data %0d cyc %0d, required no write",
                         addr_out, data_out, cyc);
            end else begin
                e = q.pop_front();
                if (e.addr == int'(addr_out) && e.data == int'(data_out) && e.cyc == cyc)
                    passed++;
                else
                    $display("FAIL write: got addr %0d data %0d cyc %0d, required addr %0d data %0d cyc %0d",
                             addr_out, data_out, cyc, e.addr, e.data, e.cyc);
            end
        end
        if (frame_done_out) begin
            dcount++;
            total++;
            if (q.size() == 0 || !q[0].is_done) begin
                $display("FAIL unexpected_done: got done at cyc %0d, required none", cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc == cyc)
                    passed++;
                else
                    $display("FAIL done_timing: got cyc %0d, required cyc %0d", cyc, e.cyc);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    task automatic chk_map(input string name, input int key, input int exp);
        total++;
        if (wmap.exists(key) && wmap[key] == exp) passed++;
        else $display("FAIL %s: got %0d, required addr %0d",
                      name, wmap.exists(key) ? wmap[key] : -1, exp);
    endtask

    task automatic chk_absent(input string name, input int key);
        total++;
        if (!wmap.exists(key)) passed++;
        else $display("FAIL %s: got write at addr %0d, required no write", name, wmap[key]);
    endtask

    task automatic drive(input bit s, input bit v, input bit e, input int d);
        sof_in   = s;
        valid_in = v;
        eol_in   = e;
        data_in  = 16'(d);
        @(posedge clk_in);
        #1;
        sof_in   = 1'b0;
        valid_in = 1'b0;
        eol_in   = 1'b0;
    endtask

    task automatic push_w(input int a, input int d);
        q.push_back('{is_done: 1'b0, addr: a, data: d, cyc: cyc + 1});
    endtask

    task automatic push_d();
        q.push_back('{is_done: 1'b1, addr: 0, data: 0, cyc: cyc + 1});
    endtask

    // Pixel (c,r) carries data r*512+c so the write map identifies it
    task automatic send_frame(input int cols, input int rows, input logic [1:0] sc,
                              input bit mir, input bit eol_with_last);
        bit dec;
        int hrows;
        dec   = (sc == 2'b01);
        hrows = dec ? 2 * H : H;
        scale_in  = sc;
        mirror_in = mir;
        wmap.delete();
        drive(1, 0, 0, 0);
        chk("busy_after_sof", int'(busy_out), 1);
        scale_in  = ~sc;
        mirror_in = ~mir;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                bit keep;
                bit last;
                int oc;
                int d;
                keep = !dec || (c % 2 == 0 && r % 2 == 0);
                oc   = dec ? c / 2 : c;
                d    = r * 512 + c;
                last = eol_with_last && (c == cols - 1);
                if (keep && oc < 240)
                    push_w((mir ? 239 - oc : oc) + 240 * (dec ? r / 2 : r), d);
                if (last && r == hrows - 1) push_d();
                drive(0, 1, last, d);
            end
            if (!eol_with_last) begin
                if (r == hrows - 1) push_d();
                drive(0, 0, 1, 0);
            end
        end
    endtask

    int w0;

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_addr", int'(addr_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_we", int'(we_out), 0);
        chk("rst_done", int'(frame_done_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        rst_in = 1'b0;
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 2);
        drive(0, 0, 0, 0);

        // 1:1, no mirror, separate eol
        w0 = wcount;
        send_frame(240, H, 2'b11, 1'b0, 1'b0);
        chk("a_busy_fall", int'(busy_out), 0);
        drive(0, 1, 0, 9);
        drive(0, 1, 1, 9);
        drive(0, 0, 0, 0);
        chk("a_writes", wcount - w0, 240 * H);
        chk("a_done_cnt", dcount, 1);
        chk_map("a_first", 0, 0);
        chk_map("a_px5_2", 2 * 512 + 5, 485);
        chk_map("a_last", 7 * 512 + 239, 1919);

        // Mirror, scale 10 treated as 1:1, eol with last pixel
        w0 = wcount;
        send_frame(240, H, 2'b10, 1'b1, 1'b1);
        drive(0, 0, 0, 0);
        chk("b_writes", wcount - w0, 240 * H);
        chk("b_done_cnt", dcount, 2);
        chk_map("b_c0_r1", 512, 479);
        chk_map("b_c239_r1", 512 + 239, 240);

        // 2:1 decimation of a 480-wide, 2*H-high input
        w0 = wcount;
        send_frame(480, 2 * H, 2'b01, 1'b0, 1'b0);
        drive(0, 0, 0, 0);
        chk("c_writes", wcount - w0, 240 * H);
        chk("c_done_cnt", dcount, 3);
        chk_map("c_px10_4", 4 * 512 + 10, 485);
        chk_absent("c_odd_col", 4 * 512 + 11);
        chk_absent("c_odd_row", 5 * 512 + 10);

        // Overlong lines cropped, then restart mid-frame
        w0 = wcount;
        send_frame(300, 3, 2'b00, 1'b0, 1'b0);
        drive(0, 0, 0, 0);
        chk("d_writes", wcount - w0, 720);
        chk_map("d_row1_start", 512, 240);
        chk_absent("d_crop", 240);

        scale_in  = 2'b01;
        mirror_in = 1'b1;
        push_w(239, 16'h7000);
        drive(1, 1, 0, 16'h7000);
        scale_in  = 2'b00;
        mirror_in = 1'b0;
        drive(0, 1, 0, 16'h7001);
        push_w(238, 16'h7002);
        drive(0, 1, 0, 16'h7002);
        drive(0, 0, 1, 0);
        drive(0, 1, 0, 16'h7003);
        drive(0, 0, 1, 0);
        push_w(479, 16'h7004);
        drive(0, 1, 0, 16'h7004);
        chk("e_busy", int'(busy_out), 1);
        chk("e_no_done", dcount, 3);

        // Asynchronous reset mid-capture
        @(negedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        chk("r_addr", int'(addr_out), 0);
        chk("r_data", int'(data_out), 0);
        chk("r_we", int'(we_out), 0);
        chk("r_busy", int'(busy_out), 0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        w0 = wcount;
        drive(0, 1, 0, 5);
        drive(0, 1, 1, 6);
        drive(0, 1, 0, 7);
        repeat (3) drive(0, 0, 0, 0);
        chk("r_no_writes", wcount - w0, 0);
        chk("r_busy_idle", int'(busy_out), 0);
        chk("queue_empty", q.size(), 0);
        chk("total_done", dcount, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
